// File: rtl/ps2_receiver.sv
// PS/2 host-side receiver: synchronizes and filters the raw pins, frames 11-bit
// keyboard frames and presents {previous byte, newest byte}. Parity checking is enabled by PS2_PARITY_CHECK_EN.
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        key_valid,
    output logic        frame_err,
    output logic [1:0]  state_dbg
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_e;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt_clk, last_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [15:0]   keycode_d;
    logic          valid_d, err_d;
    logic          parity_ok;

    // Pin synchronizers, glitch filter and falling-edge detect on the filtered clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            filt_clk <= 1'b1;
            last_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
            last_clk <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_cnt <= '0;
                filt_clk <= ~filt_clk;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign fall = last_clk & ~filt_clk;

`ifdef PS2_PARITY_CHECK_EN
    logic par_q, par_d;

    always_ff @(posedge clk) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    always_comb begin
        par_d = par_q;
        if (state_q == PARITY && fall) par_d = data_s2;
    end

    // Odd parity over the eight data bits plus the parity bit.
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            wd_q      <= '0;
            keycode   <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            wd_q      <= wd_d;
            keycode   <= keycode_d;
            key_valid <= valid_d;
            frame_err <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        wd_d      = wd_q + WW'(1);
        keycode_d = keycode;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (fall && !data_s2) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_s2, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) state_d = STOP;
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_s2 && parity_ok) begin
                        keycode_d = {keycode[7:0], shift_q};
                        valid_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A falling edge always beats a coinciding timeout.
        if (fall) begin
            wd_d = '0;
        end else if (state_q != IDLE && wd_q == WW'(TIMEOUT_CYCLES)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            wd_d    = '0;
        end
    end

    assign state_dbg = state_q;
endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: directed PS/2 frames at 12.5 kHz against a 2 MHz system clock.
`timescale 1ns/1ps
module tb_ps2_receiver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        key_valid;
    logic        frame_err;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];
    logic [15:0] kc_model = 16'h0000;

    localparam logic [1:0] K_VALID = 2'b01;
    localparam logic [1:0] K_ERR   = 2'b10;

    ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(2000)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .key_valid(key_valid), .frame_err(frame_err), .state_dbg(state_dbg)
    );

    // Clock and reset
    always #250 clk = ~clk;

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (key_valid || frame_err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got err=%0b valid=%0b keycode=%h, nothing expected",
                         frame_err, key_valid, keycode);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({frame_err, key_valid, keycode} !== e) begin
                    errors++;
                    $display("FAIL pulse got err=%0b valid=%0b keycode=%h, expected err=%0b valid=%0b keycode=%h",
                             frame_err, key_valid, keycode, e[17], e[16], e[15:0]);
                end
            end
        end
    end

    task automatic expect_pulse(input logic [1:0] kind);
        exp_q.push_back({kind, kc_model});
    endtask

    task automatic check_eq(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: LSB first, data changes in the middle of the high phase.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            #20000 ps2_data = bits[i];
            if (glitch && i == 4) begin
                ps2_clk = 1'b0;
                #1500 ps2_clk = 1'b1;
                #18500;
            end else begin
                #20000;
            end
            ps2_clk = 1'b0;
            #40000 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        #40000;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        check_eq(name, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("reset_keycode", keycode, 16'h0000);
        check_eq("reset_key_valid", {15'd0, key_valid}, 16'd0);
        check_eq("reset_frame_err", {15'd0, frame_err}, 16'd0);
        check_eq("reset_state", {14'd0, state_dbg}, 16'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single make code
        kc_model = 16'h001C; expect_pulse(K_VALID);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_drain("drain_1c");

        // Break sequence F0 1C
        kc_model = 16'h1CF0; expect_pulse(K_VALID);
        send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
        wait_drain("drain_f0");
        kc_model = 16'hF01C; expect_pulse(K_VALID);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_drain("drain_f01c");

        // Wrong parity on 0x23
`ifdef PS2_PARITY_CHECK_EN
        expect_pulse(K_ERR);
`else
        kc_model = {kc_model[7:0], 8'h23}; expect_pulse(K_VALID);
`endif
        send_frame(8'h23, 1'b1, 1'b1, 11, 1'b0);
        wait_drain("drain_parity");

        // Bad stop bit
        expect_pulse(K_ERR);
        send_frame(8'h1D, 1'b1, 1'b0, 11, 1'b0);
        wait_drain("drain_stop");

        // Short glitches while idle and mid-frame
        #20000 ps2_clk = 1'b0;
        #1500 ps2_clk = 1'b1;
        #20000;
        check_eq("glitch_idle_state", {14'd0, state_dbg}, 16'd0);
        kc_model = {kc_model[7:0], 8'h1C}; expect_pulse(K_VALID);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
        wait_drain("drain_glitch");

        // Partial frame hits the watchdog
        expect_pulse(K_ERR);
        send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0);
        repeat (2100) @(posedge clk);
        wait_drain("drain_timeout");
        @(negedge clk);
        check_eq("timeout_state", {14'd0, state_dbg}, 16'd0);
        kc_model = {kc_model[7:0], 8'h1C}; expect_pulse(K_VALID);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_drain("drain_after_timeout");
        check_eq("after_timeout_low", {8'd0, keycode[7:0]}, 16'h001C);

        // Partial frame cut short by reset
        send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0);
        @(posedge clk) rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("midreset_keycode", keycode, 16'h0000);
        check_eq("midreset_flags", {14'd0, frame_err, key_valid}, 16'd0);
        check_eq("midreset_state", {14'd0, state_dbg}, 16'd0);
        kc_model = 16'h0000;
        rst_n = 1'b1;
        repeat (2500) @(posedge clk);
        check_eq("post_reset_keycode", keycode, 16'h0000);

        // Reception restarts cleanly
        kc_model = 16'h001C; expect_pulse(K_VALID);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_drain("drain_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

PS/2 host-side receiver that deserializes keyboard frames from the raw `ps2_clk`/`ps2_data` pins into scan-code bytes. It sits directly upstream of the keyboard controller. It presents a 16-bit `keycode` with the previous byte in [15:8] and the newest byte in [7:0], so break codes appear as `F0xx`. Pin inputs are synchronized, glitch-filtered, framed by a small FSM, and protected by a watchdog.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical synchronized samples required before the filtered `ps2_clk` changes level.
- `TIMEOUT_CYCLES`, default 65000: maximum number of `clk` cycles allowed between falling edges inside a frame.

Ports:
- `clk  input  1`: system clock. All logic is on its rising edge.
- `rst_n  input  1`: reset. Synchronous, active-low.
- `ps2_clk  input  1`: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data  input  1`: raw PS/2 data pin, asynchronous to `clk`.
- `keycode  output  16`: {previous byte, newest byte}.
- `key_valid  output  1`: one-cycle strobe, high in the cycle `keycode` is updated.
- `frame_err  output  1`: one-cycle strobe, high when a frame is discarded.

## Operation
- **Synchronizer:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
- **Filter:** a counter tracks how many consecutive synchronized `ps2_clk` samples differ from the current filtered level. When it reaches `FILTER_LEN`, the filtered level flips and the counter clears. Any sample equal to the current level clears the counter.
- **Edge detect:** `fall` is high for one cycle when the filtered clock goes 1→0. All data sampling happens on `fall` and uses the synchronized `ps2_data`.
- **Frame format:** 11 bits, LSB first: start(0), d0..d7, parity (odd over d0..d7 plus parity), stop(1).
- **FSM states:**
  - IDLE: on `fall`, go to DATA if data=0. If data=1, treat it as a spurious edge and stay in IDLE with no error.
  - DATA: on each `fall`, shift data into bit 7 of the shift register and increment a 3-bit counter. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, the frame is good if data=1 and parity passes. A good frame sets `keycode <= {keycode[7:0], byte}` and pulses `key_valid`. Otherwise pulse `frame_err` and leave `keycode` unchanged. Return to IDLE in either case.
- **Watchdog:** a counter runs in any non-IDLE state and clears on every `fall`. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, the partial byte is discarded and `frame_err` pulses. The counter is held at 0 in IDLE.
- **Simultaneous events:** if `fall` and timeout coincide, `fall` wins and the watchdog clears.
- **Shift register:** no byte history is kept beyond the two bytes in `keycode`. Extended codes (E0) are passed through as ordinary bytes.

## Timing
Reset values (while `rst_n`=0 at a `clk` edge):
- Outputs: `keycode`=16'h0000, `key_valid`=0, `frame_err`=0.
- Internal: FSM in IDLE; filtered clock, both synchronizer stages and the last-level register all 1; all counters 0.
- Reset mid-frame discards the partial frame. Reception restarts with the next start bit after release.

Latency:
- Raw pin edge to `fall` is 2 synchronizer cycles plus `FILTER_LEN` cycles plus 1 cycle.
- `key_valid` and the new `keycode` appear in the cycle after the `fall` that samples the stop bit. Both are registered.

Other timing rules:
- `key_valid` and `frame_err` are never high together, and each is exactly 1 cycle wide.
- A glitch on `ps2_clk` shorter than `FILTER_LEN` cycles produces no `fall`.

## Configuration
Macro `PS2_PARITY_CHECK_EN`:
- **Defined:** a parity mismatch in STOP discards the frame and pulses `frame_err`.
- **Undefined:** the parity bit is still clocked through the PARITY state but ignored. Only the stop bit and the watchdog can cause `frame_err`.

## Test plan
Bench conventions: frames are driven at a 12.5 kHz `ps2_clk`, with data changing mid-high. `FILTER_LEN`=8 and `TIMEOUT_CYCLES`=2000.

1. After reset, send 0x1C with parity 0 → exactly one `key_valid` pulse, `keycode`=16'h001C, `frame_err` stays 0.
2. Then send 0xF0 (parity 1) followed by 0x1C (parity 0) → `keycode`=16'h1CF0 after the first frame and 16'hF01C after the second, with two `key_valid` pulses.
3. Send 0x23 with parity 1 (wrong):
   - With `PS2_PARITY_CHECK_EN` → one `frame_err` pulse, `keycode` unchanged.
   - Without it → `key_valid` pulses and `keycode[7:0]`=8'h23.
4. Send 0x1D with stop bit 0 → one `frame_err` pulse, no `key_valid`, `keycode` unchanged.
5. Inject a 3-cycle low glitch on `ps2_clk` while idle and again mid-frame → no `fall`, and the frame still decodes correctly.
6. Stop driving after the start bit and 4 data bits, then wait 2000 cycles → `frame_err` pulses and the FSM is in IDLE. A following good 0x1C frame gives `keycode[7:0]`=8'h1C. Repeat the partial frame and assert `rst_n`=0 instead → all outputs 0 and no pulses.
